// File: rtl/aes_pkg.sv
// Shared AES definitions: byte tables, Rcon, FSM encoding and GF(2^8) helpers.
// Also holds the forward AES-256 key-schedule step used by the decryptor.
package aes_pkg;

  localparam int NR = 14;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_KEYGEN = 3'd1;
  localparam logic [2:0] ST_INIT   = 3'd2;
  localparam logic [2:0] ST_ROUND  = 3'd3;
  localparam logic [2:0] ST_FINAL  = 3'd4;

  typedef logic [2:0] state_t;

  // Element 0 sits in the leftmost (most significant) byte of each table.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[b];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

  function automatic logic [7:0] rcon(input logic [2:0] i);
    logic [7:0] r;
    case (i)
      3'd1:    r = 8'h01;
      3'd2:    r = 8'h02;
      3'd3:    r = 8'h04;
      3'd4:    r = 8'h08;
      3'd5:    r = 8'h10;
      3'd6:    r = 8'h20;
      3'd7:    r = 8'h40;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a 4-bit constant; enough for the InvMixColumns coefficients.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (c[0] ? a : 8'h00) ^ (c[1] ? x2 : 8'h00) ^
           (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
  endfunction

  // Round key n from keys n-2 and n-1; even n rotates and adds Rcon[n/2].
  function automatic logic [127:0] key_step(input logic [127:0] prev2,
                                            input logic [127:0] prev1,
                                            input logic [3:0]   n);
    logic [31:0] t, w0, w1, w2, w3;
    if (!n[0])
      t = sub_word({prev1[23:0], prev1[31:24]}) ^ {rcon(n[3:1]), 24'h0};
    else
      t = sub_word(prev1[31:0]);
    w0 = prev2[127:96] ^ t;
    w1 = prev2[95:64]  ^ w0;
    w2 = prev2[63:32]  ^ w1;
    w3 = prev2[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless final_round is set.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         final_round,
  output logic [127:0] state_out
);

  logic [127:0] sub_bytes;
  logic [127:0] keyed;
  logic [127:0] mixed;

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gf_mul(a0, 4'he) ^ gf_mul(a1, 4'hb) ^ gf_mul(a2, 4'hd) ^ gf_mul(a3, 4'h9),
            gf_mul(a0, 4'h9) ^ gf_mul(a1, 4'he) ^ gf_mul(a2, 4'hb) ^ gf_mul(a3, 4'hd),
            gf_mul(a0, 4'hd) ^ gf_mul(a1, 4'h9) ^ gf_mul(a2, 4'he) ^ gf_mul(a3, 4'hb),
            gf_mul(a0, 4'hb) ^ gf_mul(a1, 4'hd) ^ gf_mul(a2, 4'h9) ^ gf_mul(a3, 4'he)};
  endfunction

  // Byte 4*c+r is row r of column c; row r rotates right by r columns.
  always_comb begin
    sub_bytes = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sub_bytes[127 - 8*(4*c + r) -: 8] =
          inv_sbox(state_in[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8]);
  end

  assign keyed = sub_bytes ^ round_key;

  always_comb begin
    mixed = '0;
    for (int c = 0; c < 4; c++)
      mixed[127 - 32*c -: 32] = inv_mix_col(keyed[127 - 32*c -: 32]);
  end

  assign state_out = final_round ? keyed : mixed;

endmodule

// File: rtl/aes_decrypt.sv
// Iterative AES-256 decryptor: expands the key on the fly after capture,
// then runs the inverse cipher one round per cycle; fixed 28-edge latency.
//
// state  | meaning
// IDLE   | waiting for ready, captures data_in/key
// KEYGEN | derives rk2..rk14, one per cycle
// INIT   | whitening with rk14
// ROUND  | full inverse rounds 13..1
// FINAL  | last round with rk0, result to data_out
module aes_decrypt
  import aes_pkg::*;
#(
  parameter int NR    = aes_pkg::NR,
  parameter int KEY_W = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ready,
  input  logic [127:0]     data_in,
  input  logic [KEY_W-1:0] key,
  output logic [127:0]     data_out,
  output logic             valid,
  output logic             busy
);

  state_t       fsm;
  logic [3:0]   cnt;
  logic [127:0] rk [0:NR];
  logic [127:0] blk;
  logic [127:0] round_out;
  logic [127:0] next_rk;
  logic         final_round;

  assign final_round = (fsm == ST_FINAL);
  assign busy        = (fsm != ST_IDLE);

  always_comb begin
    next_rk = '0;
    if (fsm == ST_KEYGEN)
      next_rk = key_step(rk[cnt - 4'd2], rk[cnt - 4'd1], cnt);
  end

  // cnt reaches 0 in FINAL, so rk[cnt] selects rk0 there.
  aes_inv_round u_inv_round (
    .state_in    (blk),
    .round_key   (rk[cnt]),
    .final_round (final_round),
    .state_out   (round_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm      <= ST_IDLE;
      cnt      <= 4'd0;
      valid    <= 1'b0;
      data_out <= '0;
    end else begin
      valid <= 1'b0;
      case (fsm)
        ST_IDLE: begin
          if (ready) begin
            fsm <= ST_KEYGEN;
            cnt <= 4'd2;
          end
        end
        ST_KEYGEN: begin
          if (cnt == 4'(NR))
            fsm <= ST_INIT;
          else
            cnt <= cnt + 4'd1;
        end
        ST_INIT: begin
          fsm <= ST_ROUND;
          cnt <= 4'(NR - 1);
        end
        ST_ROUND: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1)
            fsm <= ST_FINAL;
        end
        ST_FINAL: begin
          data_out <= round_out;
          valid    <= 1'b1;
          fsm      <= ST_IDLE;
        end
        default: fsm <= ST_IDLE;
      endcase
    end
  end

  // Round keys and the working block need no reset: always rewritten before use.
  always_ff @(posedge clk) begin
    case (fsm)
      ST_IDLE: begin
        if (ready) begin
          rk[0] <= key[KEY_W-1 -: 128];
          rk[1] <= key[127:0];
          blk   <= data_in;
        end
      end
      ST_KEYGEN: rk[cnt] <= next_rk;
      ST_INIT:   blk <= blk ^ rk[NR];
      ST_ROUND:  blk <= round_out;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aes_decrypt.sv
// Scoreboard bench for aes_decrypt: an independent AES-256 encryptor model
// produces ciphertexts, a monitor checks plaintext, latency and valid/hold behaviour.
module tb_aes_decrypt;

  localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] C3_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] SP_KEY = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] SP_CT  = 128'hf3eed1bdb5d2a03c064b5a7e3db181f8;
  localparam logic [127:0] SP_PT  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] Z_CT   = 128'hdc95c078a2408989ad48a21492842087;
  localparam int           LAT    = 28;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         ready = 1'b0;
  logic [127:0] data_in = '0;
  logic [255:0] key = '0;
  logic [127:0] data_out;
  logic         valid;
  logic         busy;

  aes_decrypt #(.NR(14), .KEY_W(256)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ready    (ready),
    .data_in  (data_in),
    .key      (key),
    .data_out (data_out),
    .valid    (valid),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [127:0] pt;
    int           due;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         mon_e;
  logic [127:0] last_out = '0;
  logic [7:0]   s_box [256];

  task automatic check(input bit ok, input string name,
                       input logic [127:0] act, input logic [127:0] want);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
  endtask

  // ---------------- reference model: textbook AES-256 encryption ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {s_box[w[31:24]], s_box[w[23:16]], s_box[w[15:8]], s_box[w[7:0]]};
  endfunction

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [255:0] k);
    logic [31:0]  w [60];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [31:0]  tmp;
    logic [127:0] res;
    for (int i = 0; i < 8; i++) w[i] = k[255 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 8; i < 60; i++) begin
      tmp = w[i-1];
      if (i % 8 == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = xt(rc);
      end else if (i % 8 == 4) begin
        tmp = subw(tmp);
      end
      w[i] = w[i-8] ^ tmp;
    end
    for (int j = 0; j < 16; j++) s[j] = pt[127 - 8*j -: 8] ^ w[j/4][31 - 8*(j%4) -: 8];
    for (int rnd = 1; rnd <= 14; rnd++) begin
      for (int j = 0; j < 16; j++) t[j] = s_box[s[j]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[4*c + r] = t[4*((c + r) % 4) + r];
      if (rnd < 14) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int j = 0; j < 16; j++) s[j] = s[j] ^ w[4*rnd + j/4][31 - 8*(j%4) -: 8];
    end
    for (int j = 0; j < 16; j++) res[127 - 8*j -: 8] = s[j];
    return res;
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, b;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      b = inv;
      s_box[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
                 {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      last_out = '0;
    end else if (exp_q.size() > 0 && cyc == exp_q[0].due) begin
      mon_e = exp_q.pop_front();
      check(valid === 1'b1, "valid_at_latency", 128'(valid), 128'd1);
      check(data_out === mon_e.pt, "data_out", data_out, mon_e.pt);
      last_out = mon_e.pt;
    end else begin
      check(valid === 1'b0, "valid_quiet", 128'(valid), 128'd0);
      check(data_out === last_out, "data_out_hold", data_out, last_out);
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input logic [255:0] k, input logic [127:0] ct,
                       input logic [127:0] pt, input bit hold);
    int waited;
    waited = 0;
    @(negedge clk);
    while (busy && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check(busy === 1'b0, "wait_idle", 128'(busy), 128'd0);
    data_in = ct;
    key     = k;
    ready   = 1'b1;
    exp_q.push_back('{pt, cyc + 1 + LAT});
    @(posedge clk);
    #1;
    check(busy === 1'b1, "busy_after_capture", 128'(busy), 128'd1);
    data_in = rnd128();
    key     = {rnd128(), rnd128()};
    if (!hold) ready = 1'b0;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] pt;
    logic [255:0] k;
    int           waited;

    build_sbox();

    repeat (3) @(posedge clk);
    #1;
    check(valid === 1'b0, "reset_valid", 128'(valid), 128'd0);
    check(busy === 1'b0, "reset_busy", 128'(busy), 128'd0);
    check(data_out === 128'h0, "reset_data_out", data_out, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(C3_KEY, C3_CT, C3_PT, 1'b0);
    issue(SP_KEY, SP_CT, SP_PT, 1'b0);
    issue(256'h0, Z_CT, 128'h0, 1'b0);

    // ready held high across several blocks while inputs keep changing
    for (int i = 0; i < 4; i++) begin
      pt = rnd128();
      k  = {rnd128(), rnd128()};
      issue(k, encrypt(pt, k), pt, 1'b1);
    end
    ready = 1'b0;

    // reset ten cycles into an operation, then immediate restart
    issue(C3_KEY, C3_CT, C3_PT, 1'b0);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete(exp_q.size() - 1);
    #1;
    check(valid === 1'b0, "abort_valid", 128'(valid), 128'd0);
    check(busy === 1'b0, "abort_busy", 128'(busy), 128'd0);
    check(data_out === 128'h0, "abort_data_out", data_out, 128'h0);
    data_in = C3_CT;
    key     = C3_KEY;
    ready   = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    exp_q.push_back('{C3_PT, cyc + 1 + LAT});
    @(posedge clk);
    #1;
    ready = 1'b0;
    check(busy === 1'b1, "accept_after_reset", 128'(busy), 128'd1);
    data_in = rnd128();
    key     = {rnd128(), rnd128()};

    // loopback with random keys and plaintexts
    for (int i = 0; i < 1000; i++) begin
      pt = rnd128();
      k  = {rnd128(), rnd128()};
      issue(k, encrypt(pt, k), pt, 1'b0);
    end

    waited = 0;
    while (exp_q.size() > 0 && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    #1;
    check(exp_q.size() == 0, "drain", 128'(exp_q.size()), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
